// File: rtl/bsg_fsb_node_ls_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bsg_fsb_node_ls_pkg: shared types for the node-domain level-shift endpoint |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package bsg_fsb_node_ls_pkg;

  typedef enum logic [1:0] {
    ISO    = 2'd0,
    WAKE   = 2'd1,
    ACTIVE = 2'd2
  } ls_state_e;

  localparam int unsigned FIFO_DEPTH = 2;

endpackage
`default_nettype wire

// File: rtl/bsg_fsb_ls_two_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bsg_fsb_ls_two_fifo: 2-entry valid/ready-in, valid/yumi-out FIFO, sync clear |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bsg_fsb_ls_two_fifo
  import bsg_fsb_node_ls_pkg::*;
#(
  parameter int width_p = 80
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i,
  output logic [1:0]         count_o
);

  logic [width_p-1:0] mem_q [FIFO_DEPTH];
  logic               rd_ptr_q, rd_ptr_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic [1:0]         count_q, count_d;
  logic               enq, deq;

  assign ready_o = (count_q != 2'(FIFO_DEPTH));
  assign v_o     = (count_q != 2'd0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  assign enq = v_i & ready_o;
  assign deq = yumi_i & v_o;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = ~wr_ptr_q;
    if (deq) rd_ptr_d = ~rd_ptr_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    // Clear wins over a same-cycle enqueue; that packet is simply lost.
    if (clear_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wr_ptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/bsg_fsb_node_ls_endpoint_node_domain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bsg_fsb_node_ls_endpoint_node_domain: node-side FSB link endpoint with     |
// | isolation wake-up FSM, buffering in both directions and flush counting.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bsg_fsb_node_ls_endpoint_node_domain
  import bsg_fsb_node_ls_pkg::*;
#(
  parameter int width_p          = 80,
  parameter int wake_cycles_p    = 4,
  parameter int drop_cnt_width_p = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        en_ls_i,
  input  logic                        fsb_v_i,
  input  logic [width_p-1:0]          fsb_data_i,
  output logic                        fsb_ready_o,
  output logic                        fsb_v_o,
  output logic [width_p-1:0]          fsb_data_o,
  input  logic                        fsb_yumi_i,
  output logic                        node_v_o,
  output logic [width_p-1:0]          node_data_o,
  input  logic                        node_yumi_i,
  input  logic                        node_v_i,
  input  logic [width_p-1:0]          node_data_i,
  output logic                        node_ready_o,
  output logic                        live_o,
  output logic [drop_cnt_width_p-1:0] drop_cnt_o
);

  localparam int WAKE_W = (wake_cycles_p > 1) ? $clog2(wake_cycles_p) : 1;
  localparam int SUM_W  = drop_cnt_width_p + 2;

  ls_state_e                   state_q, state_d;
  logic [WAKE_W-1:0]           wake_cnt_q, wake_cnt_d;
  logic [drop_cnt_width_p-1:0] drop_q, drop_d;

  logic       live, gate, flush;
  logic       a_ready, b_ready, b_v;
  logic [1:0] b_count;
  logic [SUM_W-1:0] drop_sum;

  always_comb begin
    state_d    = state_q;
    wake_cnt_d = wake_cnt_q;
    case (state_q)
      ISO: begin
        if (en_ls_i) begin
          state_d    = WAKE;
          wake_cnt_d = WAKE_W'(wake_cycles_p - 1);
        end
      end
      WAKE: begin
        if (!en_ls_i)                state_d = ISO;
        else if (wake_cnt_q == '0)   state_d = ACTIVE;
        else                         wake_cnt_d = wake_cnt_q - 1'b1;
      end
      ACTIVE: begin
        if (!en_ls_i) state_d = ISO;
      end
      default: state_d = ISO;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ISO;
      wake_cnt_q <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      wake_cnt_q <= wake_cnt_d;
      drop_q     <= drop_d;
    end
  end

  assign live  = (state_q == ACTIVE);
  assign gate  = live & en_ls_i;
  // Leaving ACTIVE this cycle: everything queued toward the FSB is discarded.
  assign flush = live & ~en_ls_i;

  bsg_fsb_ls_two_fifo #(.width_p(width_p)) fifo_a (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (1'b0),
    .v_i     (fsb_v_i & gate),
    .data_i  (fsb_data_i),
    .ready_o (a_ready),
    .v_o     (node_v_o),
    .data_o  (node_data_o),
    .yumi_i  (node_yumi_i),
    .count_o ()
  );

  bsg_fsb_ls_two_fifo #(.width_p(width_p)) fifo_b (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (flush),
    .v_i     (node_v_i),
    .data_i  (node_data_i),
    .ready_o (b_ready),
    .v_o     (b_v),
    .data_o  (fsb_data_o),
    .yumi_i  (fsb_yumi_i & gate),
    .count_o (b_count)
  );

  assign fsb_ready_o  = a_ready & live;
  assign fsb_v_o      = b_v & live;
  assign node_ready_o = b_ready & ~reset_i;
  assign live_o       = live;
  assign drop_cnt_o   = drop_q;

  assign drop_sum = SUM_W'(drop_q) + SUM_W'(b_count) + SUM_W'(node_v_i & b_ready);

  always_comb begin
    drop_d = drop_q;
    if (flush) begin
      if (drop_sum > SUM_W'({drop_cnt_width_p{1'b1}})) drop_d = '1;
      else                                             drop_d = drop_sum[drop_cnt_width_p-1:0];
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) assert (!(node_yumi_i && !node_v_o));
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bsg_fsb_node_ls_endpoint_node_domain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bsg_fsb_node_ls_endpoint_node_domain: directed + randomized checks      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_bsg_fsb_node_ls_endpoint_node_domain;

  localparam int W  = 5;
  localparam int WK = 4;
  localparam int DW = 2;
  localparam int DMAX = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          en_ls_i = 1'b0;
  logic          fsb_v_i = 1'b0, fsb_yumi_i = 1'b0, node_yumi_i = 1'b0, node_v_i = 1'b0;
  logic [W-1:0]  fsb_data_i = '0, node_data_i = '0;
  logic          fsb_ready_o, fsb_v_o, node_v_o, node_ready_o, live_o;
  logic [W-1:0]  fsb_data_o, node_data_o;
  logic [DW-1:0] drop_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bsg_fsb_node_ls_endpoint_node_domain #(
    .width_p(W), .wake_cycles_p(WK), .drop_cnt_width_p(DW)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .en_ls_i(en_ls_i),
    .fsb_v_i(fsb_v_i), .fsb_data_i(fsb_data_i), .fsb_ready_o(fsb_ready_o),
    .fsb_v_o(fsb_v_o), .fsb_data_o(fsb_data_o), .fsb_yumi_i(fsb_yumi_i),
    .node_v_o(node_v_o), .node_data_o(node_data_o), .node_yumi_i(node_yumi_i),
    .node_v_i(node_v_i), .node_data_i(node_data_i), .node_ready_o(node_ready_o),
    .live_o(live_o), .drop_cnt_o(drop_cnt_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fsb_v_i = 0; fsb_yumi_i = 0; node_yumi_i = 0; node_v_i = 0;
    fsb_data_i = '0; node_data_i = '0;
  endtask

  task automatic do_reset();
    reset_i = 1; idle_inputs(); tick(); tick(); reset_i = 0;
  endtask

  task automatic go_live();
    en_ls_i = 1;
    repeat (WK + 1) tick();
  endtask

  task automatic test_reset();
    reset_i = 1; en_ls_i = 1; idle_inputs();
    repeat (3) tick();
    checks++; if ({fsb_ready_o, fsb_v_o, node_v_o, node_ready_o, live_o} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs got %b exp 00000", {fsb_ready_o, fsb_v_o, node_v_o, node_ready_o, live_o});
    end
    checks++; if (drop_cnt_o !== '0) begin
      errors++; $display("FAIL reset_drop got %0d exp 0", drop_cnt_o);
    end
    reset_i = 0;
    for (int i = 1; i <= WK + 1; i++) begin
      tick();
      checks++; if (live_o !== (i == WK + 1) || fsb_ready_o !== (i == WK + 1)) begin
        errors++; $display("FAIL wake_timing cyc %0d live %b ready %b exp %b", i, live_o, fsb_ready_o, (i == WK + 1));
      end
    end
  endtask

  task automatic test_fill_a();
    do_reset(); go_live();
    fsb_v_i = 1; fsb_data_i = 5'h01; tick();
    checks++; if (node_v_o !== 1 || node_data_o !== 5'h01 || fsb_ready_o !== 1) begin
      errors++; $display("FAIL fill_a_first v %b data %h ready %b exp 1 01 1", node_v_o, node_data_o, fsb_ready_o);
    end
    fsb_data_i = 5'h02; tick();
    checks++; if (fsb_ready_o !== 0) begin
      errors++; $display("FAIL fill_a_full ready %b exp 0", fsb_ready_o);
    end
    fsb_data_i = 5'h03; tick();
    fsb_v_i = 0;
    checks++; if (fsb_ready_o !== 0 || node_data_o !== 5'h01) begin
      errors++; $display("FAIL fill_a_hold ready %b data %h exp 0 01", fsb_ready_o, node_data_o);
    end
    node_yumi_i = 1; tick();
    checks++; if (node_v_o !== 1 || node_data_o !== 5'h02 || fsb_ready_o !== 1) begin
      errors++; $display("FAIL fill_a_second v %b data %h ready %b exp 1 02 1", node_v_o, node_data_o, fsb_ready_o);
    end
    tick(); node_yumi_i = 0;
    checks++; if (node_v_o !== 0) begin
      errors++; $display("FAIL fill_a_drained v %b exp 0", node_v_o);
    end
  endtask

  task automatic test_back_to_back();
    fsb_yumi_i = 1;
    for (int i = 0; i < 6; i++) begin
      node_v_i = 1; node_data_i = W'(5'h0A + i); tick();
      checks++; if (fsb_v_o !== 1 || fsb_data_o !== W'(5'h0A + i)) begin
        errors++; $display("FAIL stream_b idx %0d v %b data %h exp 1 %h", i, fsb_v_o, fsb_data_o, W'(5'h0A + i));
      end
    end
    node_v_i = 0; tick(); fsb_yumi_i = 0;
    checks++; if (fsb_v_o !== 0) begin
      errors++; $display("FAIL stream_b_end v %b exp 0", fsb_v_o);
    end
  endtask

  task automatic test_flush();
    do_reset(); go_live();
    node_v_i = 1; node_data_i = 5'h11; fsb_v_i = 1; fsb_data_i = 5'h07; tick();
    fsb_v_i = 0; node_data_i = 5'h12; tick();
    node_v_i = 0;
    checks++; if (fsb_v_o !== 1 || fsb_data_o !== 5'h11) begin
      errors++; $display("FAIL flush_pre v %b data %h exp 1 11", fsb_v_o, fsb_data_o);
    end
    en_ls_i = 0; tick();
    checks++; if (fsb_v_o !== 0 || live_o !== 0 || drop_cnt_o !== 2'd2) begin
      errors++; $display("FAIL flush_post v %b live %b drop %0d exp 0 0 2", fsb_v_o, live_o, drop_cnt_o);
    end
    checks++; if (node_v_o !== 1 || node_data_o !== 5'h07) begin
      errors++; $display("FAIL flush_a_kept v %b data %h exp 1 07", node_v_o, node_data_o);
    end
    node_yumi_i = 1; tick(); node_yumi_i = 0;
    checks++; if (node_v_o !== 0) begin
      errors++; $display("FAIL flush_a_drain v %b exp 0", node_v_o);
    end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 2; k++) begin
      go_live();
      node_v_i = 1; node_data_i = W'(k); tick(); tick(); node_v_i = 0;
      checks++; if (live_o !== 1 || fsb_v_o !== 1) begin
        errors++; $display("FAIL sat_live iter %0d live %b v %b exp 1 1", k, live_o, fsb_v_o);
      end
      en_ls_i = 0; tick();
      checks++; if (drop_cnt_o !== 2'(DMAX)) begin
        errors++; $display("FAIL sat_drop iter %0d got %0d exp %0d", k, drop_cnt_o, DMAX);
      end
    end
  endtask

  task automatic test_reset_mid();
    go_live();
    fsb_v_i = 1; node_v_i = 1; fsb_data_i = 5'h15; node_data_i = 5'h16;
    tick(); tick();
    reset_i = 1; tick();
    checks++; if ({fsb_ready_o, fsb_v_o, node_v_o, node_ready_o, live_o} !== 5'b0 || drop_cnt_o !== '0) begin
      errors++; $display("FAIL reset_mid outs %b drop %0d exp 00000 0",
                         {fsb_ready_o, fsb_v_o, node_v_o, node_ready_o, live_o}, drop_cnt_o);
    end
    reset_i = 0; idle_inputs(); en_ls_i = 0; tick();
    checks++; if (node_v_o !== 0 || node_ready_o !== 1 || fsb_v_o !== 0) begin
      errors++; $display("FAIL reset_mid_empty nv %b nr %b fv %b exp 0 1 0", node_v_o, node_ready_o, fsb_v_o);
    end
  endtask

  task automatic test_glitch();
    do_reset(); en_ls_i = 0; tick();
    en_ls_i = 1; tick(); en_ls_i = 0;
    fsb_v_i = 1; fsb_data_i = 5'h1F;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (live_o !== 0 || fsb_ready_o !== 0 || node_v_o !== 0) begin
        errors++; $display("FAIL glitch cyc %0d live %b ready %b nv %b exp 0 0 0", i, live_o, fsb_ready_o, node_v_o);
      end
    end
    fsb_v_i = 0;
  endtask

  // Reference model: queues per direction; the link is live once en_ls has
  // been sampled high on more than WK consecutive edges since reset.
  task automatic test_random();
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    int run = 0;
    int drops = 0;
    bit live_m, gate_m, a_push, b_push;
    do_reset(); en_ls_i = 0;
    for (int c = 0; c < 3000; c++) begin
      en_ls_i     = ($urandom_range(0, 19) != 0);
      fsb_v_i     = $urandom_range(0, 1);
      fsb_data_i  = W'($urandom);
      node_v_i    = $urandom_range(0, 1);
      node_data_i = W'($urandom);
      fsb_yumi_i  = $urandom_range(0, 1);
      node_yumi_i = (qa.size() > 0) && ($urandom_range(0, 1) == 1);

      live_m = (run > WK);
      gate_m = live_m && en_ls_i;
      a_push = gate_m && fsb_v_i && (qa.size() < 2);
      b_push = node_v_i && (qb.size() < 2);
      if (node_yumi_i) void'(qa.pop_front());
      if (a_push) qa.push_back(fsb_data_i);
      if (live_m && !en_ls_i) begin
        drops = drops + qb.size() + int'(b_push);
        if (drops > DMAX) drops = DMAX;
        qb.delete();
      end else begin
        if (gate_m && fsb_yumi_i && qb.size() > 0) void'(qb.pop_front());
        if (b_push) qb.push_back(node_data_i);
      end
      run = en_ls_i ? run + 1 : 0;
      live_m = (run > WK);

      tick();
      checks++; if (live_o !== live_m || fsb_ready_o !== (live_m && qa.size() < 2) ||
                    fsb_v_o !== (live_m && qb.size() > 0)) begin
        errors++; $display("FAIL rand_fsb_side cyc %0d live %b ready %b v %b exp %b %b %b", c, live_o, fsb_ready_o,
                           fsb_v_o, live_m, (live_m && qa.size() < 2), (live_m && qb.size() > 0));
      end
      checks++; if (node_v_o !== (qa.size() > 0) || node_ready_o !== (qb.size() < 2)) begin
        errors++; $display("FAIL rand_node_side cyc %0d nv %b nr %b exp %b %b", c, node_v_o, node_ready_o,
                           (qa.size() > 0), (qb.size() < 2));
      end
      if (qa.size() > 0) begin
        checks++; if (node_data_o !== qa[0]) begin
          errors++; $display("FAIL rand_node_data cyc %0d got %h exp %h", c, node_data_o, qa[0]);
        end
      end
      if (live_m && qb.size() > 0) begin
        checks++; if (fsb_data_o !== qb[0]) begin
          errors++; $display("FAIL rand_fsb_data cyc %0d got %h exp %h", c, fsb_data_o, qb[0]);
        end
      end
      checks++; if (drop_cnt_o !== DW'(drops)) begin
        errors++; $display("FAIL rand_drop cyc %0d got %0d exp %0d", c, drop_cnt_o, drops);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fill_a();
    test_back_to_back();
    test_flush();
    test_saturate();
    test_reset_mid();
    test_glitch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bsg_fsb_node_ls_endpoint_node_domain.md
Name: bsg_fsb_node_ls_endpoint_node_domain

Overview:
- Node-domain end of the level-shifted FSB node link.
- Sits between the isolation/level-shift cells and the node core.
- Buffers both directions in 2-entry FIFOs and converts handshakes: fsb->node is valid/ready in and valid/yumi out; node->fsb is valid/ready in and valid/yumi out.
- Tracks the isolation enable with a wake-up FSM, so nothing crosses while isolation is active or settling.

Parameters:
- width_p, 80, packet width in bits (both directions).
- wake_cycles_p, 4, cycles after en_ls_i rises before the link is considered live; must be >= 1.
- drop_cnt_width_p, 8, width of the saturating flushed-packet counter.

Ports:
- clk_i  in  1  node-domain clock
- reset_i  in  1  synchronous, active-high reset
- en_ls_i  in  1  level-shift enable; 0 = isolation active
- fsb_v_i  in  1  packet valid from FSB side (via level shifter)
- fsb_data_i  in  width_p  packet from FSB side
- fsb_ready_o  out  1  endpoint can accept an FSB packet
- fsb_v_o  out  1  packet valid toward FSB side
- fsb_data_o  out  width_p  packet toward FSB side
- fsb_yumi_i  in  1  FSB side consumed fsb_data_o this cycle
- node_v_o  out  1  packet valid toward node core
- node_data_o  out  width_p  packet toward node core
- node_yumi_i  in  1  node core consumed node_data_o
- node_v_i  in  1  packet valid from node core
- node_data_i  in  width_p  packet from node core
- node_ready_o  out  1  endpoint can accept a node packet
- live_o  out  1  link live (FSM in ACTIVE)
- drop_cnt_o  out  drop_cnt_width_p  saturating count of packets flushed on isolation

Behaviour:
- Reset:
  - FSM goes to ISO; both FIFOs empty; wake counter = 0; drop_cnt_o = 0.
  - All outputs are 0 (fsb_ready_o, fsb_v_o, node_v_o, node_ready_o, live_o); data outputs are don't-care.
- FSM states:
  - ISO: en_ls_i=1 -> WAKE, counter loaded with wake_cycles_p-1.
  - WAKE: en_ls_i=0 -> ISO. When counter==0 -> ACTIVE; otherwise decrement.
  - ACTIVE: en_ls_i=0 -> ISO, same cycle.
- Gating:
  - fsb_v_i and fsb_yumi_i are ignored unless state==ACTIVE and en_ls_i=1.
  - fsb_ready_o and fsb_v_o are forced to 0 unless in ACTIVE.
- fsb->node path (FIFO A):
  - Enqueue when fsb_v_i & fsb_ready_o; fsb_ready_o = ~full_A & live.
  - node_v_o = ~empty_A, independent of isolation; FIFO A contents survive isolation.
  - Dequeue on node_yumi_i. Asserting yumi while node_v_o=0 is illegal (assertion).
- node->fsb path (FIFO B):
  - node_ready_o = ~full_B, independent of isolation; the node core may fill B while isolated.
  - fsb_v_o = ~empty_B & live. Dequeue on fsb_yumi_i & live.
- Isolation flush:
  - On the ACTIVE->ISO transition, FIFO B is cleared.
  - drop_cnt_o += occupancy of B (0..2), saturating at all-ones.
  - An enqueue into B in the same cycle is dropped and counted.
  - A dequeue in that cycle does not occur, because fsb_yumi_i is gated by en_ls_i=0.
- Latency: 1 cycle enqueue->valid in each direction. Full throughput: one packet per cycle with 2 entries and simultaneous enq/deq.
- Simultaneous enq+deq:
  - Allowed when full if the deq is registered first? No. Ready is based on current full, so no enqueue occurs into a full FIFO.
  - Enq+deq when occupancy is 1 leaves occupancy at 1.
- Order: FIFO order is preserved in each direction.
- en_ls_i glitch: a single-cycle high pulse in ISO enters WAKE, then returns to ISO; live_o never asserts.
- Reset mid-traffic: in the next cycle all state returns to reset values, FIFOs are emptied, and the drop counter is cleared (no counting).

Decomposition:
- Package bsg_fsb_node_ls_pkg holds:
  - state enum {ISO, WAKE, ACTIVE} (2 bits);
  - a localparam for the FIFO depth (2).
- Sub-module: bsg_fsb_ls_two_fifo (2-entry valid/ready-in, valid/yumi-out FIFO with a synchronous clear_i), instantiated twice.
- The top module holds the FSM, gating and drop counter.

Test Plan:
- Reset with en_ls_i=1, wake_cycles_p=4 -> all outputs 0 during reset; after reset, live_o rises exactly 5 cycles later (1 ISO + 4 WAKE); fsb_ready_o rises in the same cycle.
- ACTIVE, width_p=5: fsb_v_i=1 with data 5'h01, 5'h02, 5'h03 on consecutive cycles, node_yumi_i=0 -> two accepted, fsb_ready_o=0 on the third; after node_yumi_i pulses, outputs are 01 then 02 in order.
- ACTIVE, node_v_i=1 streaming 5'h0A..5'h0F, fsb_yumi_i held 1 -> fsb_data_o follows with 1-cycle latency at one packet per cycle, no gaps.
- FIFO B holds 2 packets, then en_ls_i drops -> next cycle fsb_v_o=0, live_o=0, drop_cnt_o=2; FIFO A contents are still delivered on node_yumi_i.
- drop_cnt_width_p=2: three isolation events each flushing 2 packets -> drop_cnt_o saturates at 3.
- en_ls_i 1-cycle pulse while in ISO -> live_o stays 0, fsb_v_i=1 is ignored, FIFO A stays empty; reset_i asserted mid-stream -> FIFOs are empty the next cycle and all outputs are 0.
